// File: rtl/body_sched_pkg.sv
// rtl/body_sched_pkg.sv - shared constants and types for the body frame scheduler
// Purpose: register map addresses, STATUS bit positions, scheduler FSM states
//          and the per-body parameter record handed to the renderer.
// Ports:   none (package).
package body_sched_pkg;

  localparam int PARAM_W = 10;

  localparam logic [3:0] ADDR_CTRL      = 4'd8;
  localparam logic [3:0] ADDR_STATUS    = 4'd9;
  localparam logic [3:0] ADDR_FRAME_CNT = 4'd10;

  localparam int CTRL_COMMIT_BIT    = 0;
  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_PENDING_BIT = 1;
  localparam int STATUS_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    COPY  = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic [PARAM_W-1:0] radius;
    logic [PARAM_W-1:0] x;
    logic [PARAM_W-1:0] y;
    logic [PARAM_W-1:0] z;
  } body_params_t;

endpackage

// File: rtl/vs_edge_sync.sv
// rtl/vs_edge_sync.sv - VGA vertical sync synchronizer with falling-edge detector
// Purpose: brings the asynchronous VGA_VS into the CLK domain through
//          VS_SYNC_STAGES flops and flags a synchronized 1->0 transition.
// Ports:   CLK, RESET (sync, active-high), vs_async (raw VS pin),
//          vs_fall (one-cycle pulse on a synchronized falling edge).
module vs_edge_sync #(
  parameter int VS_SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic vs_async,
  output logic vs_fall
);

  logic [VS_SYNC_STAGES-1:0] sync_q;
  logic                      prev_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[VS_SYNC_STAGES-2:0], vs_async};
      prev_q <= sync_q[VS_SYNC_STAGES-1];
    end
  end

  assign vs_fall = prev_q & ~sync_q[VS_SYNC_STAGES-1];

endmodule

// File: rtl/body_frame_scheduler.sv
// rtl/body_frame_scheduler.sv - shadow/active body parameter scheduler committed on VGA vsync
// Purpose: software fills shadow registers over Avalon-MM, commits via CTRL,
//          and the active set is copied one body per cycle after the next
//          vsync falling edge so the renderer never sees a torn frame.
// Ports:   CLK, RESET (sync, active-high); AVL_* Avalon-MM slave (4-bit word
//          address, 32-bit data, byte enables, waitrequest); VGA_VS (async,
//          active-low); ACT_RADIUS/X/Y/Z active body parameters per body;
//          FRAME_STROBE one-cycle pulse when a commit completes.
// Option:  define BODY_FRAME_COUNTER_EN to add a read-only vsync counter at
//          address 10 (reads 0 otherwise).
module body_frame_scheduler
  import body_sched_pkg::*;
#(
  parameter int N_BODIES       = 2,
  parameter int VS_SYNC_STAGES = 2
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             AVL_READ,
  input  logic                             AVL_WRITE,
  input  logic                             AVL_CS,
  input  logic [3:0]                       AVL_BYTE_EN,
  input  logic [3:0]                       AVL_ADDR,
  input  logic [31:0]                      AVL_WRITEDATA,
  output logic [31:0]                      AVL_READDATA,
  output logic                             AVL_WAITREQUEST,
  input  logic                             VGA_VS,
  output logic [N_BODIES-1:0][PARAM_W-1:0] ACT_RADIUS,
  output logic [N_BODIES-1:0][PARAM_W-1:0] ACT_X,
  output logic [N_BODIES-1:0][PARAM_W-1:0] ACT_Y,
  output logic [N_BODIES-1:0][PARAM_W-1:0] ACT_Z,
  output logic                             FRAME_STROBE
);

  localparam logic [1:0] LAST_IDX = 2'(N_BODIES - 1);

  sched_state_t state_q, state_d;
  logic [1:0]   idx_q;
  logic         pending_q;
  logic         overrun_q;
  logic         strobe_q;
  logic [31:0]  shadow_q [N_BODIES][4];
  body_params_t act_q [N_BODIES];
  logic [31:0]  rdata;
  logic [31:0]  status_word;
  logic         vs_fall;

  logic       in_copy, copy_last, wait_int, wr_en;
  logic       reg_addr, shadow_hit, commit_wr, overrun_clr;
  logic [1:0] body_sel, word_sel;

  vs_edge_sync #(
    .VS_SYNC_STAGES(VS_SYNC_STAGES)
  ) u_vs_sync (
    .CLK     (CLK),
    .RESET   (RESET),
    .vs_async(VGA_VS),
    .vs_fall (vs_fall)
  );

  assign in_copy   = (state_q == COPY);
  assign copy_last = in_copy && (idx_q == LAST_IDX);
  // Any access during COPY is held off so a write cannot land mid-copy.
  assign wait_int  = in_copy & AVL_CS & (AVL_READ | AVL_WRITE);
  assign wr_en     = AVL_CS & AVL_WRITE & ~wait_int;

  assign body_sel = AVL_ADDR[3:2];
  assign word_sel = AVL_ADDR[1:0];
  // Control addresses win over the body window (only matters for N_BODIES > 2).
  assign reg_addr   = (AVL_ADDR == ADDR_CTRL) || (AVL_ADDR == ADDR_STATUS) ||
                      (AVL_ADDR == ADDR_FRAME_CNT);
  assign shadow_hit = !reg_addr && ({30'd0, body_sel} < 32'(N_BODIES));

  assign commit_wr   = wr_en && (AVL_ADDR == ADDR_CTRL) && AVL_WRITEDATA[CTRL_COMMIT_BIT];
  assign overrun_clr = wr_en && (AVL_ADDR == ADDR_STATUS) && AVL_WRITEDATA[STATUS_OVERRUN_BIT];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < N_BODIES; b++) begin
        for (int w = 0; w < 4; w++) begin
          shadow_q[b][w] <= '0;
        end
      end
    end else if (wr_en && shadow_hit) begin
      for (int b = 0; b < N_BODIES; b++) begin
        for (int w = 0; w < 4; w++) begin
          if (body_sel == 2'(b) && word_sel == 2'(w)) begin
            for (int k = 0; k < 4; k++) begin
              if (AVL_BYTE_EN[k]) begin
                shadow_q[b][w][8*k +: 8] <= AVL_WRITEDATA[8*k +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit_wr) state_d = ARMED;
      ARMED:   if (vs_fall) state_d = COPY;
      COPY:    if (idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= copy_last;

      if (state_q == ARMED && vs_fall) begin
        idx_q <= '0;
      end else if (copy_last) begin
        idx_q <= '0;
      end else if (in_copy) begin
        idx_q <= idx_q + 2'd1;
      end

      if (copy_last) begin
        pending_q <= 1'b0;
      end else if (commit_wr) begin
        pending_q <= 1'b1;
      end

      // Set can only happen in COPY and clear only outside it, so they never collide.
      if (in_copy && vs_fall) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int b = 0; b < N_BODIES; b++) begin
        act_q[b] <= '0;
      end
    end else if (in_copy) begin
      for (int b = 0; b < N_BODIES; b++) begin
        if (idx_q == 2'(b)) begin
          act_q[b].radius <= shadow_q[b][0][PARAM_W-1:0];
          act_q[b].x      <= shadow_q[b][1][PARAM_W-1:0];
          act_q[b].y      <= shadow_q[b][2][PARAM_W-1:0];
          act_q[b].z      <= shadow_q[b][3][PARAM_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ACT_RADIUS = '0;
    ACT_X      = '0;
    ACT_Y      = '0;
    ACT_Z      = '0;
    for (int b = 0; b < N_BODIES; b++) begin
      ACT_RADIUS[b] = act_q[b].radius;
      ACT_X[b]      = act_q[b].x;
      ACT_Y[b]      = act_q[b].y;
      ACT_Z[b]      = act_q[b].z;
    end
  end

`ifdef BODY_FRAME_COUNTER_EN
  logic [31:0] frame_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_cnt_q <= '0;
    end else if (vs_fall) begin
      frame_cnt_q <= frame_cnt_q + 32'd1;
    end
  end
`endif

  always_comb begin
    status_word = '0;
    status_word[STATUS_BUSY_BIT]    = in_copy;
    status_word[STATUS_PENDING_BIT] = pending_q;
    status_word[STATUS_OVERRUN_BIT] = overrun_q;
  end

  always_comb begin
    rdata = '0;
    for (int b = 0; b < N_BODIES; b++) begin
      for (int w = 0; w < 4; w++) begin
        if (shadow_hit && body_sel == 2'(b) && word_sel == 2'(w)) begin
          rdata = shadow_q[b][w];
        end
      end
    end
    if (AVL_ADDR == ADDR_STATUS) begin
      rdata = status_word;
    end
`ifdef BODY_FRAME_COUNTER_EN
    if (AVL_ADDR == ADDR_FRAME_CNT) begin
      rdata = frame_cnt_q;
    end
`endif
  end

  // Outputs are forced quiet while RESET is held, before the reset edge lands.
  assign AVL_READDATA    = RESET ? 32'd0 : rdata;
  assign AVL_WAITREQUEST = ~RESET & wait_int;
  assign FRAME_STROBE    = ~RESET & strobe_q;

endmodule

// File: tb/tb_body_frame_scheduler.sv
// tb/tb_body_frame_scheduler.sv - self-checking bench for body_frame_scheduler
module tb_body_frame_scheduler;

  localparam int NB = 2;
  localparam int SS = 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]        AVL_BYTE_EN, AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA, AVL_READDATA;
  logic              AVL_WAITREQUEST;
  logic              VGA_VS;
  logic [NB-1:0][9:0] ACT_RADIUS, ACT_X, ACT_Y, ACT_Z;
  logic              FRAME_STROBE;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  logic [31:0]        m_shadow [NB][4];
  logic [NB-1:0][9:0] m_r, m_x, m_y, m_z;
  logic               m_pending, m_overrun;
  logic [31:0]        m_frames;

  body_frame_scheduler #(
    .N_BODIES(NB),
    .VS_SYNC_STAGES(SS)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
    .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .AVL_WAITREQUEST(AVL_WAITREQUEST), .VGA_VS(VGA_VS),
    .ACT_RADIUS(ACT_RADIUS), .ACT_X(ACT_X), .ACT_Y(ACT_Y), .ACT_Z(ACT_Z),
    .FRAME_STROBE(FRAME_STROBE)
  );

  always #10 CLK = ~CLK;

  always @(negedge CLK) if (FRAME_STROBE === 1'b1) strobes++;

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic bus_idle();
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
    AVL_BYTE_EN = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0;
  endtask

  task automatic m_reset();
    for (int b = 0; b < NB; b++)
      for (int w = 0; w < 4; w++) m_shadow[b][w] = 0;
    m_r = '0; m_x = '0; m_y = '0; m_z = '0;
    m_pending = 0; m_overrun = 0; m_frames = 0;
  endtask

  task automatic m_copy();
    for (int b = 0; b < NB; b++) begin
      m_r[b] = m_shadow[b][0][9:0];
      m_x[b] = m_shadow[b][1][9:0];
      m_y[b] = m_shadow[b][2][9:0];
      m_z[b] = m_shadow[b][3][9:0];
    end
    m_pending = 0;
  endtask

  // Bus write that waits out WAITREQUEST, then applies the register rules to the model.
  task automatic avl_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] be, output int waits);
    int a;
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = addr; AVL_WRITEDATA = data; AVL_BYTE_EN = be;
    waits = 0;
    #1;
    while (AVL_WAITREQUEST === 1'b1 && waits < 50) begin
      @(posedge CLK);
      #2;
      waits++;
    end
    if (waits >= 50) begin
      errors++;
      $display("FAIL write_timeout addr=%0d waitrequest stuck high", addr);
    end
    @(posedge CLK);
    #1;
    bus_idle();
    a = int'(addr);
    if (a < 4 * NB) begin
      for (int k = 0; k < 4; k++)
        if (be[k]) m_shadow[a / 4][a % 4][8*k +: 8] = data[8*k +: 8];
    end else if (a == 8 && data[0]) begin
      m_pending = 1;
    end else if (a == 9 && data[2]) begin
      m_overrun = 0;
    end
  endtask

  task automatic avl_read(input logic [3:0] addr, output logic [31:0] data, output logic wq);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = addr;
    #1;
    data = AVL_READDATA;
    wq = AVL_WAITREQUEST;
    @(posedge CLK);
    #1;
    bus_idle();
  endtask

  task automatic vs_pulse();
    VGA_VS = 0;
    cyc(SS + NB + 3);
    VGA_VS = 1;
    cyc(SS + 3);
    m_frames++;
    if (m_pending) m_copy();
  endtask

  task automatic fill_random();
    int w;
    for (int a = 0; a < 4 * NB; a++) avl_write(4'(a), $urandom, 4'hF, w);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic wq;
    RESET = 1; VGA_VS = 1; bus_idle();
    cyc(3);
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 4'd9;
    #1;
    checks++;
    if (AVL_READDATA !== 0 || AVL_WAITREQUEST !== 0 || FRAME_STROBE !== 0) begin
      errors++;
      $display("FAIL reset_gating rdata=%h wq=%b strobe=%b required 0/0/0",
               AVL_READDATA, AVL_WAITREQUEST, FRAME_STROBE);
    end
    bus_idle();
    cyc();
    RESET = 0;
    m_reset();
    cyc(SS + 3);
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== '0) begin
      errors++;
      $display("FAIL reset_act got=%h required 0", {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z});
    end
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 0 || wq !== 0) begin
      errors++;
      $display("FAIL reset_status got=%h wq=%b required 0", d, wq);
    end
    for (int a = 0; a < 4 * NB; a++) begin
      avl_read(4'(a), d, wq);
      checks++;
      if (d !== 0) begin
        errors++;
        $display("FAIL reset_shadow addr=%0d got=%h required 0", a, d);
      end
    end
  endtask

  task automatic test_byte_merge();
    logic [31:0] d;
    logic wq;
    int w, a;
    avl_write(4'd1, 32'h0000_0123, 4'b1111, w);
    avl_read(4'd1, d, wq);
    checks++;
    if (d !== 32'h0000_0123 || wq !== 1'b0) begin
      errors++;
      $display("FAIL merge_full got=%h wq=%b required 00000123 wq=0", d, wq);
    end
    avl_write(4'd1, 32'h0000_AB00, 4'b0010, w);
    avl_read(4'd1, d, wq);
    checks++;
    if (d !== 32'h0000_AB23) begin
      errors++;
      $display("FAIL merge_byte1 got=%h required 0000ab23", d);
    end
    for (int be = 0; be < 16; be++) begin
      a = $urandom_range(0, 4 * NB - 1);
      avl_write(4'(a), $urandom, 4'(be), w);
      avl_read(4'(a), d, wq);
      checks++;
      if (d !== m_shadow[a / 4][a % 4]) begin
        errors++;
        $display("FAIL merge_be be=%h addr=%0d got=%h required %h", be, a, d, m_shadow[a / 4][a % 4]);
      end
    end
    avl_read(4'd8, d, wq);
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL ctrl_reads_zero got=%h required 0", d);
    end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    logic wq;
    logic [9:0] old_x;
    int w, s0;
    avl_write(4'd1, 32'd100, 4'hF, w);
    avl_write(4'd8, 32'd1, 4'hF, w);
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 32'd2) begin
      errors++;
      $display("FAIL latency_pending got=%h required 2", d);
    end
    old_x = m_x[0];
    s0 = strobes;
    VGA_VS = 0;
    for (int k = 1; k <= SS + 2; k++) begin
      cyc();
      checks++;
      if (ACT_X[0] !== ((k < SS + 2) ? old_x : 10'd100)) begin
        errors++;
        $display("FAIL latency_x0 cycle=%0d got=%0d required %0d", k, ACT_X[0],
                 (k < SS + 2) ? old_x : 10'd100);
      end
    end
    cyc(NB + 1);
    VGA_VS = 1;
    cyc(SS + 3);
    m_frames++;
    m_copy();
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== {m_r, m_x, m_y, m_z}) begin
      errors++;
      $display("FAIL latency_act got=%h required %h", {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z}, {m_r, m_x, m_y, m_z});
    end
    checks++;
    if (strobes - s0 !== 1) begin
      errors++;
      $display("FAIL latency_strobe got=%0d required 1", strobes - s0);
    end
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL latency_status_after got=%h required 0", d);
    end
  endtask

  task automatic test_random_frames();
    int w, s0;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 4 * NB; a++) avl_write(4'(a), $urandom, 4'($urandom_range(0, 15)), w);
      avl_write(4'd8, 32'd1, 4'hF, w);
      s0 = strobes;
      vs_pulse();
      checks++;
      if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== {m_r, m_x, m_y, m_z}) begin
        errors++;
        $display("FAIL frame_act it=%0d got=%h required %h", it,
                 {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z}, {m_r, m_x, m_y, m_z});
      end
      checks++;
      if (strobes - s0 !== 1) begin
        errors++;
        $display("FAIL frame_strobe it=%0d got=%0d required 1", it, strobes - s0);
      end
    end
  endtask

  task automatic test_write_during_copy();
    logic [31:0] d, nd;
    logic wq;
    int w, s0;
    fill_random();
    avl_write(4'd8, 32'd1, 4'hF, w);
    nd = m_shadow[1][1] ^ 32'h0000_03FF;
    s0 = strobes;
    VGA_VS = 0;
    cyc(SS + 1);
    m_copy();
    avl_write(4'd5, nd, 4'hF, w);
    checks++;
    if (w !== NB) begin
      errors++;
      $display("FAIL copy_stall_cycles got=%0d required %0d", w, NB);
    end
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== {m_r, m_x, m_y, m_z}) begin
      errors++;
      $display("FAIL copy_no_tear got=%h required %h", {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z}, {m_r, m_x, m_y, m_z});
    end
    avl_read(4'd5, d, wq);
    checks++;
    if (d !== nd) begin
      errors++;
      $display("FAIL copy_write_lands got=%h required %h", d, nd);
    end
    VGA_VS = 1;
    cyc(SS + 3);
    m_frames++;
    checks++;
    if (strobes - s0 !== 1) begin
      errors++;
      $display("FAIL copy_strobe got=%0d required 1", strobes - s0);
    end
  endtask

  task automatic test_no_commit();
    logic [31:0] d;
    logic wq;
    int w, s0;
    fill_random();
    avl_write(4'd8, 32'd0, 4'hF, w);
    s0 = strobes;
    vs_pulse();
    vs_pulse();
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== {m_r, m_x, m_y, m_z}) begin
      errors++;
      $display("FAIL nocommit_act got=%h required %h", {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z}, {m_r, m_x, m_y, m_z});
    end
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 0 || strobes - s0 !== 0) begin
      errors++;
      $display("FAIL nocommit_status status=%h strobes=%0d required 0/0", d, strobes - s0);
    end
    avl_write(4'd8, 32'd1, 4'hF, w);
    avl_write(4'd8, 32'd1, 4'hF, w);
    vs_pulse();
    vs_pulse();
    checks++;
    if (strobes - s0 !== 1) begin
      errors++;
      $display("FAIL double_commit_strobe got=%0d required 1", strobes - s0);
    end
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== {m_r, m_x, m_y, m_z}) begin
      errors++;
      $display("FAIL double_commit_act got=%h required %h", {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z}, {m_r, m_x, m_y, m_z});
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic wq;
    int w, s0;
    fill_random();
    avl_write(4'd8, 32'd1, 4'hF, w);
    s0 = strobes;
    VGA_VS = 0; cyc();
    VGA_VS = 1; cyc();
    VGA_VS = 0; cyc(SS + NB + 3);
    VGA_VS = 1; cyc(SS + 3);
    m_frames += 2;
    m_copy();
    m_overrun = 1;
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== {29'd0, m_overrun, m_pending, 1'b0}) begin
      errors++;
      $display("FAIL overrun_set got=%h required 4", d);
    end
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== {m_r, m_x, m_y, m_z} || strobes - s0 !== 1) begin
      errors++;
      $display("FAIL overrun_frame act=%h strobes=%0d required %h/1",
               {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z}, strobes - s0, {m_r, m_x, m_y, m_z});
    end
    avl_write(4'd9, 32'd0, 4'hF, w);
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 32'd4) begin
      errors++;
      $display("FAIL overrun_sticky got=%h required 4", d);
    end
    avl_write(4'd9, 32'd4, 4'hF, w);
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL overrun_clear got=%h required 0", d);
    end
  endtask

  task automatic test_reset_during_copy();
    logic [31:0] d;
    logic wq;
    int w;
    fill_random();
    avl_write(4'd0, 32'h0000_0155, 4'hF, w);
    avl_write(4'd8, 32'd1, 4'hF, w);
    VGA_VS = 0;
    cyc(SS + 2);
    RESET = 1;
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 4'd9;
    #1;
    checks++;
    if (AVL_READDATA !== 0 || AVL_WAITREQUEST !== 0 || FRAME_STROBE !== 0) begin
      errors++;
      $display("FAIL reset_in_copy_gating rdata=%h wq=%b strobe=%b required 0/0/0",
               AVL_READDATA, AVL_WAITREQUEST, FRAME_STROBE);
    end
    bus_idle();
    cyc();
    RESET = 0;
    m_reset();
    checks++;
    if ({ACT_RADIUS, ACT_X, ACT_Y, ACT_Z} !== '0) begin
      errors++;
      $display("FAIL reset_in_copy_act got=%h required 0", {ACT_RADIUS, ACT_X, ACT_Y, ACT_Z});
    end
    avl_read(4'd9, d, wq);
    checks++;
    if (d !== 0 || wq !== 0) begin
      errors++;
      $display("FAIL reset_in_copy_status got=%h wq=%b required 0/0", d, wq);
    end
    avl_read(4'd0, d, wq);
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL reset_in_copy_shadow got=%h required 0", d);
    end
    VGA_VS = 1;
    cyc(SS + 3);
  endtask

  task automatic test_frame_counter();
    logic [31:0] d, exp_cnt;
    logic wq;
    RESET = 1; cyc(); RESET = 0;
    m_reset();
    cyc(SS + 3);
    vs_pulse(); vs_pulse(); vs_pulse();
`ifdef BODY_FRAME_COUNTER_EN
    exp_cnt = m_frames;
`else
    exp_cnt = 0;
`endif
    avl_read(4'd10, d, wq);
    checks++;
    if (d !== exp_cnt) begin
      errors++;
      $display("FAIL frame_counter got=%h required %h", d, exp_cnt);
    end
`ifdef BODY_FRAME_COUNTER_EN
    @(negedge CLK);
    force dut.frame_cnt_q = 32'hFFFF_FFFF;
    @(negedge CLK);
    release dut.frame_cnt_q;
    cyc();
    vs_pulse();
    avl_read(4'd10, d, wq);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL frame_counter_wrap got=%h required 0", d);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_byte_merge();
    test_latency();
    test_random_frames();
    test_write_during_copy();
    test_no_commit();
    test_overrun();
    test_reset_during_copy();
    test_frame_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/body_frame_scheduler.md
BODY_FRAME_SCHEDULER -- requirements
Module: body_frame_scheduler

Interface
REQ-001 SHALL have parameter N_BODIES, default 2: number of bodies, 1..4.
REQ-002 SHALL have parameter VS_SYNC_STAGES, default 2: synchronizer depth on VGA_VS, minimum 2.
REQ-003 SHALL have port CLK, input, 1: 50 MHz system clock.
REQ-004 SHALL have port RESET, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports AVL_READ, AVL_WRITE and AVL_CS, input, 1 each: Avalon-MM read, write and chip select.
REQ-006 SHALL have port AVL_BYTE_EN, input, 4: Avalon-MM byte enables.
REQ-007 SHALL have port AVL_ADDR, input, 4: word address.
REQ-008 SHALL have port AVL_WRITEDATA, input, 32: Avalon-MM write data.
REQ-009 SHALL have port AVL_READDATA, output, 32: Avalon-MM read data.
REQ-010 SHALL have port AVL_WAITREQUEST, output, 1: stalls the Avalon access.
REQ-011 SHALL have port VGA_VS, input, 1: asynchronous, active-low vertical sync.
REQ-012 SHALL have ports ACT_RADIUS, ACT_X, ACT_Y and ACT_Z, output, [N_BODIES][10] each: active body parameters sent to the renderer.
REQ-013 SHALL have port FRAME_STROBE, output, 1: one-cycle pulse when a commit completes.

Function
REQ-014 Shadow register map: body b owns addresses 4b..4b+3, holding radius, x, y and z. Address 8 is CTRL; address 9 is STATUS.
REQ-015 A write to a shadow register with CS=1, WRITE=1 and WAITREQUEST=0 SHALL merge each byte whose enable bit is set; all 16 byte-enable masks are legal.
REQ-016 A read SHALL return the shadow word, or STATUS at address 9, combinationally in the same cycle. Unmapped addresses and CTRL SHALL read 0.
REQ-017 Writing CTRL with bit0=1 SHALL set PENDING. Writing bit0=0 SHALL have no effect. Writing bit0=1 while PENDING is already set SHALL have no effect.
REQ-018 STATUS SHALL read bit0=BUSY (state COPY), bit1=PENDING and bit2=OVERRUN.
REQ-019 VGA_VS SHALL pass through VS_SYNC_STAGES flops. A synchronized 1->0 transition SHALL produce a one-cycle vs_fall pulse.
REQ-020 FSM states SHALL be IDLE, ARMED and COPY.
REQ-021 IDLE->ARMED on the cycle PENDING is set.
REQ-022 ARMED->COPY on vs_fall; the copy index SHALL load 0.
REQ-023 In COPY, each cycle SHALL copy body[idx], bits [9:0] of its 4 shadow words, into the ACT_* outputs and then increment idx.
REQ-024 When idx=N_BODIES-1, COPY->IDLE; PENDING SHALL clear and FRAME_STROBE SHALL pulse in the following cycle.
REQ-025 Latency: body b SHALL become active VS_SYNC_STAGES+2+b cycles after VGA_VS falls at the pin.
REQ-026 In COPY, AVL_WAITREQUEST SHALL equal AVL_CS & (AVL_READ | AVL_WRITE), so writes stall and never tear a frame. Outside COPY, AVL_WAITREQUEST SHALL be 0.
REQ-027 A vs_fall in IDLE SHALL be ignored. A vs_fall in COPY (cannot occur for legal VGA timing) SHALL set sticky OVERRUN.
REQ-028 OVERRUN SHALL clear only when STATUS is written with bit2=1.
REQ-029 A CTRL commit arriving in the same cycle as vs_fall in ARMED SHALL be a no-op, since PENDING is already set.
REQ-030 ACT_* outputs SHALL change only in COPY.

Reset
REQ-031 RESET SHALL clear all shadow registers, the ACT_* outputs, PENDING, OVERRUN, idx and the synchronizer flops to 0, and force the FSM to IDLE.
REQ-032 A RESET during COPY SHALL abort the copy; the ACT_* outputs SHALL read 0 on the next cycle.
REQ-033 While RESET=1, AVL_READDATA, AVL_WAITREQUEST and FRAME_STROBE SHALL be 0.

Configuration
REQ-034 With macro BODY_FRAME_COUNTER_EN defined, address 10 SHALL be a 32-bit read-only counter, reset to 0, incremented on every vs_fall and wrapping from 0xFFFFFFFF to 0.
REQ-035 Without BODY_FRAME_COUNTER_EN, address 10 SHALL read 0 and no counter logic SHALL exist.

Structure
REQ-036 Package body_sched_pkg SHALL hold the address constants, the STATUS bit positions, the FSM state enum and the body_params_t struct (radius, x, y, z, 10 bits each).
REQ-037 The synchronizer and edge detector SHALL be sub-module vs_edge_sync, parameterized by VS_SYNC_STAGES.

Verification
REQ-038 Write addr1=0x0000_0123 with BE=1111, then read addr1 -> 0x0000_0123 with zero wait. Write BE=0010 with data 0x0000_AB00 -> read 0x0000_AB23.
REQ-039 Write x=100 for body 0, commit, then drop VGA_VS -> ACT_X[0] stays 0 until exactly VS_SYNC_STAGES+2 cycles after the edge, then reads 100; FRAME_STROBE pulses once.
REQ-040 Write issued during COPY -> WAITREQUEST=1 for the remaining copy cycles, then the write lands. ACT_* keep the pre-write values for that frame.
REQ-041 Two vs_fall pulses with no commit -> ACT_* unchanged and STATUS=0. Commit twice before the edge -> exactly one copy and one FRAME_STROBE.
REQ-042 Assert RESET in the second COPY cycle with N_BODIES=2 -> all ACT_* are 0 next cycle, STATUS=0, FSM in IDLE.
REQ-043 With BODY_FRAME_COUNTER_EN, 3 vs_fall pulses -> addr10 reads 3. Preload the counter to 0xFFFFFFFF via a force, then one vs_fall -> addr10 reads 0.
